// File: rtl/mp_limb_seq_if.sv
// Request/completion and limb-RAM port bundle for the multi-precision add/subtract sequencer.
// The master side is the issue logic plus the RAM. The slave side is the sequencer.
interface mp_limb_seq_if #(
  parameter int LIMB_W = 64,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] d_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [LIMB_W-1:0] rd_data_a;
  logic [LIMB_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LIMB_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              flag_c;
  logic              flag_z;
  logic [1:0]        dbg_state;

  // Handshake: start is taken only when the sequencer is idle and not pulsing done.
  // busy covers the whole operation, and done is a single-cycle pulse with the flags.
  // The RAM returns rd_data_* one cycle after rd_en and commits writes on the wr_en edge.
  modport master (
    output start, op, a_base, b_base, d_base, rd_data_a, rd_data_b,
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  busy, done, flag_c, flag_z, dbg_state
  );

  modport slave (
    input  start, op, a_base, b_base, d_base, rd_data_a, rd_data_b,
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output busy, done, flag_c, flag_z, dbg_state
  );
endinterface

// File: rtl/mp_limb_seq.sv
// Multi-precision ADD/SUB/NEG/CMP sequencer. It streams limb pairs from a synchronous RAM
// through one LIMB_W-bit adder, chains the carry between limbs, and writes result limbs back.
module mp_limb_seq #(
  parameter int LIMB_W = 64,
  parameter int NLIMBS = 4,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  mp_limb_seq_if.slave bus
);
  localparam int CNT_W = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NLIMBS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  idx;
  logic              drain_cnt;
  logic              rd_vld;
  logic              c_q;
  logic              z_acc;
  logic [LIMB_W-1:0] x;
  logic [LIMB_W-1:0] y;
  logic [LIMB_W:0]   sum;

  assign bus.dbg_state = state;

  // The carry register starts at 1 for the subtract family, so ~B + 1 forms the two's complement.
  always_comb begin
    x = bus.rd_data_a;
    y = ~bus.rd_data_b;
    if (op_q == OP_ADD) begin
      y = bus.rd_data_b;
    end else if (op_q == OP_NEG) begin
      x = '0;
      y = ~bus.rd_data_a;
    end
    sum = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, c_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      wr_ptr        <= '0;
      idx           <= '0;
      drain_cnt     <= 1'b0;
      rd_vld        <= 1'b0;
      c_q           <= 1'b0;
      z_acc         <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_z    <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.wr_en <= 1'b0;
      rd_vld    <= bus.rd_en;

      // The read data for limb i arrives one cycle after its read strobe.
      // The adder result is registered as the write for that limb.
      if (rd_vld) begin
        bus.wr_en   <= (op_q != OP_CMP);
        bus.wr_addr <= wr_ptr;
        bus.wr_data <= sum[LIMB_W-1:0];
        wr_ptr      <= wr_ptr + ADDR_W'(1);
        c_q         <= sum[LIMB_W];
        if (sum[LIMB_W-1:0] != '0) z_acc <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A start that arrives in the done cycle is dropped, so the block stays idle for that cycle.
          if (bus.start && !bus.done) begin
            state         <= ISSUE;
            op_q          <= bus.op;
            bus.rd_en     <= 1'b1;
            bus.rd_addr_a <= bus.a_base;
            bus.rd_addr_b <= bus.b_base;
            wr_ptr        <= bus.d_base;
            idx           <= '0;
            bus.busy      <= 1'b1;
            c_q           <= (bus.op != OP_ADD);
            z_acc         <= 1'b1;
          end
        end
        ISSUE: begin
          if (idx == LAST_IDX) begin
            bus.rd_en <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            idx           <= idx + CNT_W'(1);
            bus.rd_addr_a <= bus.rd_addr_a + ADDR_W'(1);
            bus.rd_addr_b <= bus.rd_addr_b + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.flag_c <= (op_q == OP_ADD) ? c_q : ~c_q;
            bus.flag_z <= z_acc;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_limb_seq.sv
// Directed bench for mp_limb_seq. A behavioural limb RAM sits on the bus.
// A negedge monitor checks every write and done pulse against the expected queues.
module tb_mp_limb_seq;
  localparam int LIMB_W = 64;
  localparam int NLIMBS = 4;
  localparam int ADDR_W = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  mp_limb_seq_if #(.LIMB_W(LIMB_W), .ADDR_W(ADDR_W)) bus ();

  mp_limb_seq #(.LIMB_W(LIMB_W), .NLIMBS(NLIMBS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- limb RAM (read-first) with a poke port for preload ----------------
  logic [LIMB_W-1:0] mem [0:255];
  logic              poke_en = 1'b0;
  logic [7:0]        poke_addr = '0;
  logic [63:0]       poke_data = '0;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem[bus.rd_addr_a];
      bus.rd_data_b <= mem[bus.rd_addr_b];
    end
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  // ---------------- scoreboard ----------------
  logic [71:0] exp_wr_q[$];    // {addr, data}
  logic [33:0] exp_done_q[$];  // {cycle, flag_c, flag_z}

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [63:0] data);
    exp_wr_q.push_back({addr, data});
  endtask

  task automatic push_done(input int c, input logic fc, input logic fz);
    exp_done_q.push_back({c[31:0], fc, fz});
  endtask

  always @(negedge clk) begin
    logic [71:0] ew;
    logic [33:0] ed;
    if (bus.wr_en) begin
      check(exp_wr_q.size() != 0, "wr_unexpected", {56'd0, bus.wr_addr}, 64'd0);
      if (exp_wr_q.size() != 0) begin
        ew = exp_wr_q.pop_front();
        check(bus.wr_addr == ew[71:64], "wr_addr", {56'd0, bus.wr_addr}, {56'd0, ew[71:64]});
        check(bus.wr_data == ew[63:0], "wr_data", bus.wr_data, ew[63:0]);
      end
    end
    if (bus.done) begin
      check(exp_done_q.size() != 0, "done_unexpected", 64'd1, 64'd0);
      if (exp_done_q.size() != 0) begin
        ed = exp_done_q.pop_front();
        check(cyc == int'(ed[33:2]), "done_cycle", 64'(cyc), {32'd0, ed[33:2]});
        check(bus.flag_c == ed[1], "flag_c", {63'd0, bus.flag_c}, {63'd0, ed[1]});
        check(bus.flag_z == ed[0], "flag_z", {63'd0, bus.flag_z}, {63'd0, ed[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] addr, input logic [63:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic load4(input logic [7:0] base, input logic [63:0] l0, input logic [63:0] l1,
                       input logic [63:0] l2, input logic [63:0] l3);
    poke(base, l0);
    poke(base + 8'd1, l1);
    poke(base + 8'd2, l2);
    poke(base + 8'd3, l3);
  endtask

  // Starts one operation. k is the cycle in which start was high.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, output int k);
    @(negedge clk);
    bus.op = op; bus.a_base = a; bus.b_base = b; bus.d_base = d; bus.start = 1'b1;
    k = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done && exp_wr_q.size() == 0 && exp_done_q.size() == 0) ok = 1'b1;
    end
    check(ok, "idle_timeout", {32'd0, exp_wr_q.size()}, 64'd0);
    exp_wr_q.delete();
    exp_done_q.delete();
  endtask

  task automatic push_wr4(input logic [7:0] d, input logic [63:0] l0, input logic [63:0] l1,
                          input logic [63:0] l2, input logic [63:0] l3);
    push_wr(d, l0); push_wr(d + 8'd1, l1); push_wr(d + 8'd2, l2); push_wr(d + 8'd3, l3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit seen;
    bus.start = 1'b0; bus.op = 2'b00;
    bus.a_base = '0; bus.b_base = '0; bus.d_base = '0;

    repeat (3) @(negedge clk);
    check(bus.busy == 1'b0, "rst_busy", {63'd0, bus.busy}, 64'd0);
    check(bus.done == 1'b0, "rst_done", {63'd0, bus.done}, 64'd0);
    check(bus.rd_en == 1'b0, "rst_rd_en", {63'd0, bus.rd_en}, 64'd0);
    check(bus.wr_en == 1'b0, "rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check({bus.flag_c, bus.flag_z} == 2'b00, "rst_flags", {62'd0, bus.flag_c, bus.flag_z}, 64'd0);
    rst = 1'b0;

    // ADD carry chain: limb0 FFFF.. + 1 carries into limb1.
    load4(8'h10, ONES, 64'd0, 64'd0, 64'd0);
    load4(8'h20, 64'd1, 64'd0, 64'd0, 64'd0);
    push_wr4(8'h30, 64'd0, 64'd1, 64'd0, 64'd0);
    issue(2'b00, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b0, 1'b0);
    wait_idle();

    // ADD overflow: all-ones + 1.
    load4(8'h10, ONES, ONES, ONES, ONES);
    push_wr4(8'h30, 64'd0, 64'd0, 64'd0, 64'd0);
    issue(2'b00, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b1, 1'b1);
    wait_idle();

    // SUB with borrow: 1 - 2.
    load4(8'h10, 64'd1, 64'd0, 64'd0, 64'd0);
    load4(8'h20, 64'd2, 64'd0, 64'd0, 64'd0);
    push_wr4(8'h30, ONES, ONES, ONES, ONES);
    issue(2'b01, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b1, 1'b0);
    wait_idle();

    // SUB equal operands: 5 - 5.
    load4(8'h10, 64'd5, 64'd0, 64'd0, 64'd0);
    load4(8'h20, 64'd5, 64'd0, 64'd0, 64'd0);
    push_wr4(8'h30, 64'd0, 64'd0, 64'd0, 64'd0);
    issue(2'b01, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b0, 1'b1);
    wait_idle();

    // NEG of 0, then NEG of 1.
    load4(8'h10, 64'd0, 64'd0, 64'd0, 64'd0);
    push_wr4(8'h30, 64'd0, 64'd0, 64'd0, 64'd0);
    issue(2'b10, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b0, 1'b1);
    wait_idle();

    load4(8'h10, 64'd1, 64'd0, 64'd0, 64'd0);
    push_wr4(8'h30, ONES, ONES, ONES, ONES);
    issue(2'b10, 8'h10, 8'h20, 8'h30, k);
    push_done(k + NLIMBS + 3, 1'b1, 1'b0);
    wait_idle();

    // CMP 3 vs 7: borrow set, no writes, destination untouched.
    load4(8'h10, 64'd3, 64'd0, 64'd0, 64'd0);
    load4(8'h20, 64'd7, 64'd0, 64'd0, 64'd0);
    load4(8'h70, 64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD);
    issue(2'b11, 8'h10, 8'h20, 8'h70, k);
    push_done(k + NLIMBS + 3, 1'b1, 1'b0);
    wait_idle();
    check(mem[8'h70] == 64'hAAAA, "cmp_ram_d0", mem[8'h70], 64'hAAAA);
    check(mem[8'h73] == 64'hDDDD, "cmp_ram_d3", mem[8'h73], 64'hDDDD);
    check(mem[8'h10] == 64'd3, "cmp_ram_a0", mem[8'h10], 64'd3);

    // Reset two writes in: only limbs 0 and 1 land, no done, flags clear.
    load4(8'h10, 64'd1, 64'd2, 64'd3, 64'd4);
    load4(8'h20, 64'd1, 64'd1, 64'd1, 64'd1);
    push_wr(8'h60, 64'd2);
    push_wr(8'h61, 64'd3);
    issue(2'b00, 8'h10, 8'h20, 8'h60, k);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(bus.busy == 1'b0, "mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check(bus.wr_en == 1'b0, "mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check(bus.rd_en == 1'b0, "mid_rst_rd_en", {63'd0, bus.rd_en}, 64'd0);
    check({bus.flag_c, bus.flag_z} == 2'b00, "mid_rst_flags", {62'd0, bus.flag_c, bus.flag_z}, 64'd0);
    rst = 1'b0;
    push_wr4(8'h60, 64'd2, 64'd3, 64'd4, 64'd5);
    issue(2'b00, 8'h10, 8'h20, 8'h60, k);
    push_done(k + NLIMBS + 3, 1'b0, 1'b0);
    wait_idle();

    // In-place ADD with a start pulse while busy, then a start during the done cycle.
    load4(8'h40, 64'd5, 64'd6, 64'd7, 64'd8);
    load4(8'h20, 64'd1, 64'd2, 64'd3, 64'd4);
    push_wr4(8'h40, 64'd6, 64'd8, 64'd10, 64'd12);
    issue(2'b00, 8'h40, 8'h20, 8'h40, k);
    push_done(k + NLIMBS + 3, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(seen, "done_timeout", {63'd0, seen}, 64'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check(bus.busy == 1'b0, "start_at_done_ignored", {63'd0, bus.busy}, 64'd0);
    wait_idle();
    check(mem[8'h40] == 64'd6, "inplace_l0", mem[8'h40], 64'd6);
    check(mem[8'h43] == 64'd12, "inplace_l3", mem[8'h43], 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mp_limb_seq.md
Name: mp_limb_seq

Overview:
- Multi-precision add/subtract sequencer for the ECC field datapath.
- Walks an NLIMBS-limb operand pair, stored one limb per address in a synchronous limb RAM, through an internal LIMB_W-bit adder one limb per cycle, chaining carry/borrow between limbs.
- Writes result limbs back to the RAM and reports final carry/borrow and zero flags.
- Sits between the instruction decode/issue logic (start/done handshake) and the limb RAM read/write ports.

Parameters:
LIMB_W, 64, width of one limb and of the adder
NLIMBS, 4, limbs per operand (>=1)
ADDR_W, 8, limb RAM address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only while idle
op  input  2  00 ADD, 01 SUB, 10 NEG, 11 CMP
a_base  input  ADDR_W  address of limb 0 of operand A
b_base  input  ADDR_W  address of limb 0 of operand B (ignored for NEG)
d_base  input  ADDR_W  address of limb 0 of result
rd_en  output  1  RAM read strobe
rd_addr_a  output  ADDR_W  A read address
rd_addr_b  output  ADDR_W  B read address
rd_data_a  input  LIMB_W  A data, valid 1 cycle after rd_en
rd_data_b  input  LIMB_W  B data, valid 1 cycle after rd_en
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_W  write address
wr_data  output  LIMB_W  write data
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
flag_c  output  1  ADD: final carry; SUB/NEG/CMP: final borrow
flag_z  output  1  all result limbs zero

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0, captured op and bases cleared.
- FSM states:
  - IDLE to ISSUE on start.
  - ISSUE runs NLIMBS cycles.
  - DRAIN runs 2 cycles.
  - DRAIN returns to IDLE with done.
- Accept at cycle S: start=1 in IDLE. Capture op and bases. busy=1 from S+1 through S+N+2 (N=NLIMBS); busy=0 at S+N+3.
- Issue, cycles S+1..S+N, limb i=0..N-1:
  - rd_en=1
  - rd_addr_a = a_base+i
  - rd_addr_b = b_base+i
  - Addresses wrap mod 2^ADDR_W.
- Compute, cycle S+2+i: sum = X + Y + c, LIMB_W+1 bits.
  - ADD: X=A, Y=B.
  - SUB/CMP: X=A, Y=~B.
  - NEG: X=0, Y=~A.
  - Carry register c is set at accept: 0 for ADD, 1 otherwise. It is updated to sum[LIMB_W] each limb.
- Write, registered, cycle S+3+i:
  - wr_en=1 except for CMP, where wr_en stays 0 throughout.
  - wr_addr = d_base+i.
  - wr_data = sum[LIMB_W-1:0].
- Completion, cycle S+N+3: done=1 for exactly one cycle.
  - flag_c = final c for ADD, ~final c for SUB/NEG/CMP.
  - flag_z = 1 iff every result limb was zero, CMP included.
  - Flags update only at done and hold until the next done or reset.
- Total latency: N+3 cycles from accept to done.
- start while busy: ignored, no queueing.
- start in the same cycle as done: ignored. The block is idle again at S+N+4.
- RAM is read-first. In-place operation (d_base equal to a_base or b_base) is supported. Other overlapping placements are undefined.
- Reset mid-operation:
  - Takes effect next edge.
  - Writes stop immediately, so partial results remain in RAM.
  - No done is produced.
  - Flags clear to 0.
- NLIMBS=1: same timing with N=1.

Test Plan:
- ADD carry chain (N=4, LIMB_W=64): A={0,0,0,FFFF_FFFF_FFFF_FFFF}, B={0,0,0,1}, little-endian limb 0 last -> writes limb0=0, limb1=1, limbs2-3=0 at S+3..S+6. done at S+7, flag_c=0, flag_z=0.
- ADD overflow: A=all-ones (4 limbs), B=1 -> all four result limbs 0, flag_c=1, flag_z=1.
- SUB borrow: A=1, B=2 -> all limbs FFFF_FFFF_FFFF_FFFF, flag_c=1. Then A=5, B=5 -> all zero, flag_c=0, flag_z=1.
- NEG/CMP:
  - NEG of 0 -> result 0, flag_c=0, flag_z=1.
  - CMP with A=3, B=7 -> no wr_en ever, flag_c=1, flag_z=0.
  - RAM contents unchanged.
- Handshake: start pulsed at S+2 during busy -> ignored, exactly one done at S+N+3. In-place ADD with d_base=a_base -> correct sum.
- Reset: rst at S+4 -> wr_en=0 and busy=0 from S+5, no done, flags=0. New start at S+6 -> completes normally at S+6+N+3.
